morse_key_sequencer: RTL

- Converts a single raw Morse key input into timed dot/dash symbols.
- Packs up to five symbols into the 2-bit slot format used by the Morse decoder: 00 empty, 01 dot, 10 dash.
- Detects the inter-letter gap and pulses letter_done so the decoder latches the character.
- Sits between the board key/button and the decoder; owns all key timing and letter sequencing.

---
 rtl/morse_pkg.sv | 19 +
 rtl/morse_tick_gen.sv | 35 +++
 rtl/morse_key_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared symbol codes, FSM state encoding and letter limits for the Morse key sequencer.
package morse_pkg;

   localparam int MAX_SYMBOLS = 5;

   typedef enum logic [1:0] {
      SYM_EMPTY = 2'b00,
      SYM_DOT   = 2'b01,
      SYM_DASH  = 2'b10
   } sym_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PRESS = 2'b01,
      GAP   = 2'b10,
      DONE  = 2'b11
   } state_e;

endpackage

// File: rtl/morse_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, restartable so that
// durations measured from a state entry are exact multiples of TICK_DIV.
module morse_tick_gen #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;

   assign tick = (presc_q == LAST);

   always_comb begin
      presc_d = presc_q + 1'b1;
      if (restart || tick) begin
         presc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/morse_key_sequencer.sv
// Turns a raw Morse key into dot/dash symbols packed into five decoder slots,
// and pulses letter_done (or err_overflow) once the inter-letter gap elapses.
module morse_key_sequencer
   import morse_pkg::*;
#(
   parameter int TICK_DIV        = 100000,
   parameter int MIN_PRESS_TICKS = 10,
   parameter int DOT_MAX_TICKS   = 200,
   parameter int GAP_TICKS       = 600,
   parameter int CNT_W           = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_in,
   input  logic       clear,
   output logic [1:0] morse_one,
   output logic [1:0] morse_two,
   output logic [1:0] morse_three,
   output logic [1:0] morse_four,
   output logic [1:0] morse_five,
   output logic       letter_done,
   output logic [2:0] symbol_count,
   output logic       key_active,
   output logic       err_overflow
);

   localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_PRESS_TICKS);
   localparam logic [CNT_W-1:0] DOT_T = CNT_W'(DOT_MAX_TICKS);
   localparam logic [CNT_W-1:0] GAP_T = CNT_W'(GAP_TICKS);
   localparam logic [2:0]       MAX_C = 3'(MAX_SYMBOLS);

   logic             ks_meta_q;
   logic             ks_q;
   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] dur_q;
   logic [CNT_W-1:0] dur_d;
   logic [CNT_W-1:0] dur_now;
   logic             ovf_q;
   logic             ovf_d;
   logic [1:0]       slot_q [MAX_SYMBOLS];
   logic [1:0]       slot_d [MAX_SYMBOLS];
   logic [2:0]       count_q;
   logic [2:0]       count_d;
   logic             letter_done_q;
   logic             letter_done_d;
   logic             err_q;
   logic             err_d;
   logic             restart;
   logic             tick;
   logic             is_glitch;
   logic [1:0]       sym;

   morse_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   // Fold in the tick landing this cycle so a release measures the full press.
   assign dur_now   = (tick && (dur_q != '1)) ? dur_q + 1'b1 : dur_q;
   assign is_glitch = (dur_now < MIN_T);
   assign sym       = (dur_now < DOT_T) ? SYM_DOT : SYM_DASH;
   assign restart   = (state_d != state_q);
   assign dur_d     = restart ? '0 : dur_now;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ks_meta_q <= 1'b0;
         ks_q      <= 1'b0;
         state_q   <= IDLE;
         dur_q     <= '0;
      end else begin
         ks_meta_q <= key_in;
         ks_q      <= ks_meta_q;
         state_q   <= state_d;
         dur_q     <= dur_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (ks_q) state_d = PRESS;
            end
            PRESS: begin
               if (!ks_q) begin
                  if (is_glitch && (count_q == 3'd0) && !ovf_q) state_d = IDLE;
                  else                                          state_d = GAP;
               end
            end
            GAP: begin
               if (ks_q)                  state_d = PRESS;
               else if (dur_now >= GAP_T) state_d = DONE;
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Slot file only changes on a completed press, clear, or leaving DONE.
   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (clear || (state_q == DONE)) begin
         for (int i = 0; i < MAX_SYMBOLS; i++) slot_d[i] = SYM_EMPTY;
         count_d = 3'd0;
         ovf_d   = 1'b0;
      end else if ((state_q == PRESS) && !ks_q && !is_glitch) begin
         if (count_q < MAX_C) begin
            for (int i = 0; i < MAX_SYMBOLS; i++) begin
               if (count_q == 3'(i)) slot_d[i] = sym;
            end
            count_d = count_q + 3'd1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_comb begin
      letter_done_d = (state_d == DONE) && !ovf_q;
      err_d         = (state_d == DONE) && ovf_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < MAX_SYMBOLS; i++) slot_q[i] <= SYM_EMPTY;
         count_q       <= 3'd0;
         ovf_q         <= 1'b0;
         letter_done_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         slot_q        <= slot_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         letter_done_q <= letter_done_d;
         err_q         <= err_d;
      end
   end

   assign morse_one    = slot_q[0];
   assign morse_two    = slot_q[1];
   assign morse_three  = slot_q[2];
   assign morse_four   = slot_q[3];
   assign morse_five   = slot_q[4];
   assign symbol_count = count_q;
   assign key_active   = ks_q;
   assign letter_done  = letter_done_q;
   assign err_overflow = err_q;

endmodule
